// File: rtl/ms_es_mul_seq_ctrl_if.sv
// ms_es_mul_seq_ctrl_if
// Bundles the operand handshake, datapath control/status and result handshake
// of the stochastic-multiplier sequencer.
//   slave  : sequencer side (drives in_ready, dp_*, out_*, busy)
//   master : environment side (drives in_valid/in_data, flush, dp_done,
//            dp_result, out_ready)
// Optional: when MS_ES_SEQ_CYCLE_COUNT_EN is defined the bundle also carries
// out_cycles ($clog2(MAX_CYCLES+1) bits), and MAX_CYCLES becomes a parameter.
interface ms_es_mul_seq_ctrl_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 10
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
  , parameter int MAX_CYCLES = 1024
`endif
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic                             flush;
  logic                             dp_rst;
  logic                             dp_en;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] dp_bin_in;
  logic                             dp_done;
  logic [WXIP1-1:0]                 dp_result;
  logic                             out_valid;
  logic                             out_ready;
  logic [WXIP1-1:0]                 out_data;
  logic                             out_timeout;
  logic                             busy;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
  logic [$clog2(MAX_CYCLES+1)-1:0]  out_cycles;
`endif

  modport slave (
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    output out_cycles,
`endif
    input  in_valid, in_data, flush, dp_done, dp_result, out_ready,
    output in_ready, dp_rst, dp_en, dp_bin_in, out_valid, out_data,
           out_timeout, busy
  );

  modport master (
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    input  out_cycles,
`endif
    output in_valid, in_data, flush, dp_done, dp_result, out_ready,
    input  in_ready, dp_rst, dp_en, dp_bin_in, out_valid, out_data,
           out_timeout, busy
  );
endinterface

// File: rtl/ms_es_mul_seq_ctrl.sv
// ms_es_mul_seq_ctrl
// Operation sequencer for the ordered stride-4 stochastic multiplier datapath.
// Accepts one operand vector, holds it on dp_bin_in, clears the datapath for
// CLR_CYCLES, runs it (ignoring dp_done for the first SETTLE_CYCLES cycles),
// drains for DRAIN_CYCLES, then presents dp_result on the result handshake.
// A vector containing a zero operand skips the datapath and returns 0.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ms_es_mul_seq_ctrl_if.slave: in_valid/in_ready/in_data, flush,
//          dp_rst/dp_en/dp_bin_in/dp_done/dp_result,
//          out_valid/out_ready/out_data/out_timeout, busy
// Optional: define MS_ES_SEQ_CYCLE_COUNT_EN to add bus.out_cycles, the RUN
// cycle count of the returned result (0 for a zero skip).
module ms_es_mul_seq_ctrl #(
  parameter int DATA_WIDTH    = 5,
  parameter int NUM_INPUTS    = 2,
  parameter int WXIP1         = 10,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_CYCLES  = 1,
  parameter int MAX_CYCLES    = 1024
) (
  input logic               clk,
  input logic               rst,
  ms_es_mul_seq_ctrl_if.slave bus
);
  localparam int OPW       = NUM_INPUTS * DATA_WIDTH;
  localparam int CW        = $clog2(MAX_CYCLES + 1);
  localparam int PHASE_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] CLR_LAST   = PW'(CLR_CYCLES - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RUN_MAX    = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_DRAIN, ST_OUT} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    phase_reg, phase_next;        // cycle index inside CLEAR / DRAIN
  logic [CW-1:0]    run_cnt_reg, run_cnt_next;
  logic             to_flag_reg, to_flag_next;
  logic [OPW-1:0]   op_reg, op_next;
  logic [WXIP1-1:0] out_data_reg, out_data_next;
  logic             out_timeout_reg, out_timeout_next;
  logic             out_valid_reg, out_valid_next;
  logic             dp_rst_reg, dp_en_reg, busy_reg;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
  logic [CW-1:0]    cycles_reg, cycles_next;
`endif

  logic [NUM_INPUTS-1:0] operand_zero;
  logic                  in_ready_w, accept, qual_done;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_zero
      assign operand_zero[gi] = (bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH] == '0);
    end
  endgenerate

  // in_ready is the only combinational output; it is forced low during reset.
  assign in_ready_w = (state_reg == ST_IDLE) & ~bus.flush & rst;
  assign accept     = bus.in_valid & in_ready_w;
  // The datapath raises a stale done right after its reset; only trust it
  // once the settle window has passed.
  assign qual_done  = bus.dp_done & (run_cnt_reg > SETTLE_CNT);

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    run_cnt_next     = run_cnt_reg;
    to_flag_next     = to_flag_reg;
    op_next          = op_reg;
    out_data_next    = out_data_reg;
    out_timeout_next = out_timeout_reg;
    out_valid_next   = 1'b0;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    cycles_next      = cycles_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next      = bus.in_data;
          phase_next   = '0;
          run_cnt_next = '0;
          to_flag_next = 1'b0;
          if (|operand_zero) begin
            state_next       = ST_OUT;
            out_data_next    = '0;
            out_timeout_next = 1'b0;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
            cycles_next      = '0;
`endif
          end else begin
            state_next = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (phase_reg == CLR_LAST) begin
          state_next   = ST_RUN;
          phase_next   = '0;
          run_cnt_next = CW'(1);
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      ST_RUN: begin
        // done beats a simultaneous timeout
        if (qual_done) begin
          state_next   = ST_DRAIN;
          to_flag_next = 1'b0;
        end else if (run_cnt_reg == RUN_MAX) begin
          state_next   = ST_DRAIN;
          to_flag_next = 1'b1;
        end else begin
          run_cnt_next = (run_cnt_reg < RUN_MAX) ? run_cnt_reg + CW'(1) : RUN_MAX;
        end
      end
      ST_DRAIN: begin
        if (phase_reg == DRAIN_LAST) begin
          state_next       = ST_OUT;
          phase_next       = '0;
          out_data_next    = bus.dp_result;
          out_timeout_next = to_flag_reg;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
          cycles_next      = run_cnt_reg;
`endif
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      ST_OUT: begin
        // out_valid rises one cycle after entering OUT; leave only on a
        // real handshake so the result is never dropped.
        if (out_valid_reg && bus.out_ready) begin
          state_next   = ST_IDLE;
          run_cnt_next = '0;
        end else begin
          out_valid_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_next     = ST_IDLE;
      phase_next     = '0;
      run_cnt_next   = '0;
      to_flag_next   = 1'b0;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= '0;
      run_cnt_reg     <= '0;
      to_flag_reg     <= 1'b0;
      op_reg          <= '0;
      out_data_reg    <= '0;
      out_timeout_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      dp_rst_reg      <= 1'b1;
      dp_en_reg       <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
      cycles_reg      <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      run_cnt_reg     <= run_cnt_next;
      to_flag_reg     <= to_flag_next;
      op_reg          <= op_next;
      out_data_reg    <= out_data_next;
      out_timeout_reg <= out_timeout_next;
      out_valid_reg   <= out_valid_next;
      dp_rst_reg      <= (state_next == ST_CLEAR);
      dp_en_reg       <= (state_next == ST_RUN);
      busy_reg        <= (state_next != ST_IDLE);
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
      cycles_reg      <= cycles_next;
`endif
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.dp_rst      = dp_rst_reg;
  assign bus.dp_en       = dp_en_reg;
  assign bus.dp_bin_in   = op_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.out_timeout = out_timeout_reg;
  assign bus.busy        = busy_reg;
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
  assign bus.out_cycles  = cycles_reg;
`endif
endmodule

// File: tb/tb_ms_es_mul_seq_ctrl.sv
// tb_ms_es_mul_seq_ctrl
// Directed bench for ms_es_mul_seq_ctrl (W=5, N=2, WXIP1=10, MAX_CYCLES=16)
// with a behavioural datapath that raises a stale done after dp_rst.
// Honours MS_ES_SEQ_CYCLE_COUNT_EN for the out_cycles checks.
module tb_ms_es_mul_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  int         mdl_mode = 0;      // 0 normal, 1 done always high, 2 done never
  int         mdl_done_at = 5;
  logic [9:0] mdl_fixed = '0;
  int         mdl_en_cnt = 0;
  logic [9:0] mdl_prod;

  ms_es_mul_seq_ctrl_if #(
    .DATA_WIDTH(5), .NUM_INPUTS(2), .WXIP1(10)
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    , .MAX_CYCLES(16)
`endif
  ) bus ();

  ms_es_mul_seq_ctrl #(
    .DATA_WIDTH(5), .NUM_INPUTS(2), .WXIP1(10), .CLR_CYCLES(2),
    .SETTLE_CYCLES(2), .DRAIN_CYCLES(1), .MAX_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign mdl_prod = 10'(bus.dp_bin_in[4:0]) * 10'(bus.dp_bin_in[9:5]);

  always @(posedge clk) begin
    if (!rst) begin
      mdl_en_cnt    <= 0;
      bus.dp_done   <= 1'b0;
      bus.dp_result <= '0;
    end else if (bus.dp_rst) begin
      mdl_en_cnt  <= 0;
      bus.dp_done <= (mdl_mode != 2);
    end else if (bus.dp_en) begin
      mdl_en_cnt <= mdl_en_cnt + 1;
      case (mdl_mode)
        0: begin
          bus.dp_done   <= (mdl_en_cnt + 1 >= mdl_done_at);
          bus.dp_result <= mdl_prod;
        end
        1: begin
          bus.dp_done   <= 1'b1;
          bus.dp_result <= (mdl_en_cnt + 1 >= 20) ? mdl_prod : 10'(mdl_en_cnt + 1);
        end
        default: begin
          bus.dp_done   <= 1'b0;
          bus.dp_result <= mdl_fixed;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Latency counts cycles from the accept cycle to the first out_valid cycle.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b,
                       output int lat, output int n_en, output int n_rst);
    int guard;
    bus.in_data  = {b, a};
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1; n_en = 0; n_rst = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.dp_en === 1'b1) n_en++;
      if (bus.dp_rst === 1'b1) n_rst++;
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL op_wait: out_valid=%b required 1 within 200 cycles", bus.out_valid);
    end
    $display("[TB] op %0d*%0d -> out_data=%0d timeout=%b latency=%0d en=%0d", a, b,
             bus.out_data, bus.out_timeout, lat, n_en);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_data = 10'h3FF; bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    tests_run++; if (bus.dp_rst !== 1'b1) begin tests_failed++; $display("FAIL rst_dp_rst: got %b required 1", bus.dp_rst); end
    tests_run++; if (bus.dp_en !== 1'b0) begin tests_failed++; $display("FAIL rst_dp_en: got %b required 0", bus.dp_en); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    tests_run++; if (bus.out_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_out_timeout: got %b required 0", bus.out_timeout); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    tests_run++; if (bus.out_data !== 10'd0) begin tests_failed++; $display("FAIL rst_out_data: got %0h required 0", bus.out_data); end
    tests_run++; if (bus.dp_bin_in !== 10'd0) begin tests_failed++; $display("FAIL rst_dp_bin_in: got %0h required 0", bus.dp_bin_in); end
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    tests_run++; if (bus.out_cycles !== 5'd0) begin tests_failed++; $display("FAIL rst_out_cycles: got %0d required 0", bus.out_cycles); end
`endif
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_in_ready: got %b required 1", bus.in_ready); end
    tick();
    tests_run++; if (bus.dp_rst !== 1'b0) begin tests_failed++; $display("FAIL idle_dp_rst: got %b required 0", bus.dp_rst); end
  endtask

  task automatic test_basic();
    int lat, n_en, n_rst;
    mdl_mode = 0; mdl_done_at = 5;
    do_op(5'd3, 5'd5, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd15) begin tests_failed++; $display("FAIL basic_data: got %0d required 15", bus.out_data); end
    tests_run++; if (bus.out_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: got %b required 0", bus.out_timeout); end
    tests_run++; if (n_rst != 2) begin tests_failed++; $display("FAIL basic_dp_rst_cycles: got %0d required 2", n_rst); end
    tests_run++; if (n_en != 6) begin tests_failed++; $display("FAIL basic_dp_en_cycles: got %0d required 6", n_en); end
    tests_run++; if (lat != 11) begin tests_failed++; $display("FAIL basic_latency: got %0d required 11", lat); end
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    tests_run++; if (bus.out_cycles !== 5'd6) begin tests_failed++; $display("FAIL basic_out_cycles: got %0d required 6", bus.out_cycles); end
`endif
    release_result();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_release: out_valid got %b required 0", bus.out_valid); end
  endtask

  task automatic test_zero_skip();
    int lat, n_en, n_rst;
    mdl_mode = 0; mdl_done_at = 5;
    do_op(5'd0, 5'd17, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd0) begin tests_failed++; $display("FAIL zero_data: got %0d required 0", bus.out_data); end
    tests_run++; if (bus.out_timeout !== 1'b0) begin tests_failed++; $display("FAIL zero_timeout: got %b required 0", bus.out_timeout); end
    tests_run++; if (n_en != 0) begin tests_failed++; $display("FAIL zero_dp_en: got %0d cycles required 0", n_en); end
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL zero_latency: got %0d required 2", lat); end
    tests_run++; if (bus.dp_bin_in !== 10'h220) begin tests_failed++; $display("FAIL zero_dp_bin_in: got %0h required 220", bus.dp_bin_in); end
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    tests_run++; if (bus.out_cycles !== 5'd0) begin tests_failed++; $display("FAIL zero_out_cycles: got %0d required 0", bus.out_cycles); end
`endif
    release_result();
    do_op(5'd9, 5'd0, lat, n_en, n_rst);
    tests_run++; if (lat != 2 || n_en != 0) begin tests_failed++; $display("FAIL zero_hi_operand: latency %0d en %0d required 2 and 0", lat, n_en); end
    release_result();
  endtask

  task automatic test_early_done();
    int lat, n_en, n_rst;
    mdl_mode = 1;
    do_op(5'd4, 5'd4, lat, n_en, n_rst);
    tests_run++; if (n_en != 3) begin tests_failed++; $display("FAIL early_dp_en_cycles: got %0d required 3", n_en); end
    tests_run++; if (bus.out_data !== 10'd3) begin tests_failed++; $display("FAIL early_data: got %0d required 3", bus.out_data); end
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL early_latency: got %0d required 8", lat); end
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    tests_run++; if (bus.out_cycles !== 5'd3) begin tests_failed++; $display("FAIL early_out_cycles: got %0d required 3", bus.out_cycles); end
`endif
    release_result();
  endtask

  task automatic test_timeout();
    int lat, n_en, n_rst;
    mdl_mode = 2; mdl_fixed = 10'h3A5;
    do_op(5'd7, 5'd3, lat, n_en, n_rst);
    tests_run++; if (bus.out_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_flag: got %b required 1", bus.out_timeout); end
    tests_run++; if (bus.out_data !== 10'h3A5) begin tests_failed++; $display("FAIL timeout_data: got %0h required 3a5", bus.out_data); end
    tests_run++; if (n_en != 16) begin tests_failed++; $display("FAIL timeout_run_cycles: got %0d required 16", n_en); end
    tests_run++; if (lat != 21) begin tests_failed++; $display("FAIL timeout_latency: got %0d required 21", lat); end
`ifdef MS_ES_SEQ_CYCLE_COUNT_EN
    tests_run++; if (bus.out_cycles !== 5'd16) begin tests_failed++; $display("FAIL timeout_out_cycles: got %0d required 16", bus.out_cycles); end
`endif
    release_result();
  endtask

  task automatic test_hold();
    int lat, n_en, n_rst;
    mdl_mode = 0; mdl_done_at = 3;
    do_op(5'd6, 5'd7, lat, n_en, n_rst);
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 10'd42 || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: valid=%b data=%0d in_ready=%b required 1 42 0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release_valid: got %b required 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release_in_ready: got %b required 1", bus.in_ready); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL hold_release_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, n_en, n_rst;
    mdl_mode = 0; mdl_done_at = 1;
    do_op(5'd31, 5'd31, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd961) begin tests_failed++; $display("FAIL b2b_max_data: got %0d required 961", bus.out_data); end
    tests_run++; if (n_en != 3 || lat != 8) begin tests_failed++; $display("FAIL b2b_max_timing: en %0d latency %0d required 3 and 8", n_en, lat); end
    release_result();
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready); end
    do_op(5'd1, 5'd1, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd1) begin tests_failed++; $display("FAIL b2b_min_data: got %0d required 1", bus.out_data); end
    release_result();
  endtask

  task automatic test_flush();
    int lat, n_en, n_rst, guard;
    mdl_mode = 2; mdl_fixed = 10'h155;
    bus.in_data = {5'd9, 5'd7};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.dp_en !== 1'b1 && guard < 20) begin tick(); guard++; end
    tests_run++; if (bus.dp_en !== 1'b1) begin tests_failed++; $display("FAIL flush_reach_run: dp_en %b required 1", bus.dp_en); end
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b required 0", bus.busy); end
    tests_run++; if (bus.dp_en !== 1'b0) begin tests_failed++; $display("FAIL flush_dp_en: got %b required 0", bus.dp_en); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b required 0", bus.out_valid); end
    tests_run++; if (bus.dp_bin_in !== 10'h127) begin tests_failed++; $display("FAIL flush_op_kept: got %0h required 127", bus.dp_bin_in); end
    bus.in_valid = 1'b1;
    bus.in_data = {5'd2, 5'd1};
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b required 0", bus.in_ready); end
    tick();
    tests_run++; if (bus.busy !== 1'b0 || bus.dp_bin_in !== 10'h127) begin
      tests_failed++; $display("FAIL flush_no_accept: busy %b dp_bin_in %0h required 0 and 127", bus.busy, bus.dp_bin_in);
    end
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    mdl_mode = 0; mdl_done_at = 2;
    do_op(5'd4, 5'd6, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd24 || bus.out_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL flush_next_op: data %0d timeout %b required 24 and 0", bus.out_data, bus.out_timeout);
    end
    release_result();
  endtask

  task automatic test_rst_drain();
    int lat, n_en, n_rst, guard;
    mdl_mode = 0; mdl_done_at = 4;
    bus.in_data = {5'd11, 5'd2};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.dp_en !== 1'b1 && guard < 20) begin tick(); guard++; end
    guard = 0;
    while (bus.dp_en === 1'b1 && guard < 40) begin tick(); guard++; end
    tests_run++; if (bus.busy !== 1'b1 || bus.dp_en !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstd_in_drain: busy %b dp_en %b out_valid %b required 1 0 0", bus.busy, bus.dp_en, bus.out_valid);
    end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstd_busy: got %b required 0", bus.busy); end
    tests_run++; if (bus.dp_rst !== 1'b1 || bus.dp_en !== 1'b0) begin tests_failed++; $display("FAIL rstd_dp: dp_rst %b dp_en %b required 1 and 0", bus.dp_rst, bus.dp_en); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rstd_in_ready: got %b required 0", bus.in_ready); end
    tests_run++; if (bus.out_data !== 10'd0 || bus.dp_bin_in !== 10'd0) begin
      tests_failed++; $display("FAIL rstd_regs: out_data %0d dp_bin_in %0h required 0 and 0", bus.out_data, bus.dp_bin_in);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    do_op(5'd6, 5'd5, lat, n_en, n_rst);
    tests_run++; if (bus.out_data !== 10'd30 || bus.out_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL rstd_next_op: data %0d timeout %b required 30 and 0", bus.out_data, bus.out_timeout);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_skip();
    test_early_done();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_flush();
    test_rst_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
